// File: rtl/apb_ram_slave.sv
// apb_ram_slave: APB3 target memory behind the axi2apb32 bridge.
// It adds programmable wait states, error responses for out-of-range and
// misaligned addresses, and a sticky checker for APB protocol violations.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no transfer; waits for a setup phase (PSEL & ~PENABLE)
// ACCESS | setup seen; counts wait states, then completes with PREADY
// ERRACK | PENABLE was seen without a setup; one-cycle error response
module apb_ram_slave #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [31:0]           PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  proto_err,
  output logic [7:0]            err_cnt
);

  // Parameter sanity: the wait counter is 8 bits wide and the bridge is 32-bit.
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 255) begin : g_bad_wait
    $error("apb_ram_slave: WAIT_CYCLES must be in 0..255");
  end
  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("apb_ram_slave: DATA_WIDTH must be 32");
  end

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_CYCLES);
  localparam int         DEPTH    = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERRACK = 2'd2
  } state_t;

  state_t                  state;
  logic [7:0]              cnt;
  logic                    pwrite_q;
  logic                    bad_q;
  logic [31:0]             paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;

  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0]   idx;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic                    bad;
  logic                    ready_int;
  logic                    complete;
  logic                    mem_we;
  logic                    err_evt;
  logic                    changed;

  // Address decode of the live bus and of the address latched at setup.
  always_comb begin
    idx   = PADDR[ADDR_WIDTH+1:2];
    idx_q = paddr_q[ADDR_WIDTH+1:2];
    bad   = (PADDR[31:ADDR_WIDTH+2] != '0) || (PADDR[1:0] != 2'b00);
  end

  // Handshake outputs are decoded from state so that reset drops them at once.
  always_comb begin
    ready_int = 1'b0;
    PSLVERR   = 1'b0;
    case (state)
      ACCESS: begin
        ready_int = (cnt == WAIT_LIM);
        PSLVERR   = (cnt == WAIT_LIM) && bad_q;
      end
      ERRACK: begin
        ready_int = 1'b1;
        PSLVERR   = 1'b1;
      end
      default: begin
        ready_int = 1'b0;
        PSLVERR   = 1'b0;
      end
    endcase
    PREADY = ready_int;
  end

  // Completion, write-enable and error-event strobes for the current cycle.
  always_comb begin
    complete = (state == ACCESS) && ready_int && PSEL && PENABLE;
    mem_we   = complete && pwrite_q && !bad_q;
    err_evt  = (complete && bad_q) || (state == ERRACK);
    changed  = (PADDR != paddr_q) || (PWRITE != pwrite_q) || (PWDATA != pwdata_q);
  end

  // Memory array: not reset; a write lands only on a completing access edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= PWDATA;
    end
  end

  // Transfer FSM with its registered read data and sticky protocol flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      pwrite_q  <= 1'b0;
      bad_q     <= 1'b0;
      paddr_q   <= 32'd0;
      pwdata_q  <= '0;
      PRDATA    <= '0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            pwrite_q <= PWRITE;
            bad_q    <= bad;
            paddr_q  <= PADDR;
            pwdata_q <= PWDATA;
            cnt      <= 8'd0;
            PRDATA   <= (bad || PWRITE) ? '0 : mem[idx];
            state    <= ACCESS;
          end else if (PSEL && PENABLE) begin
            proto_err <= 1'b1;
            state     <= ERRACK;
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            // Master abandoned the transfer: nothing is written.
            proto_err <= 1'b1;
            state     <= IDLE;
          end else if (ready_int) begin
            if (PENABLE) begin
              state <= IDLE;
            end else begin
              proto_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
            // The transfer keeps its latched address even if the bus moves.
            if (!PENABLE || changed) begin
              proto_err <= 1'b1;
            end
          end
        end
        ERRACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Saturating count of error responses delivered to the bridge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (err_evt && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_apb_ram_slave.sv
// Self-checking bench for apb_ram_slave: a zero-wait and a three-wait
// instance share one APB bus, with PSEL steered to one of them at a time.
module tb_apb_ram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = 32'd0;
  logic [31:0] pwdata = 32'd0;
  logic        dsel = 1'b0;

  logic        psel_a, psel_b;
  logic [31:0] prdata_a, prdata_b, prdata;
  logic        pready_a, pready_b, pready;
  logic        pslverr_a, pslverr_b, pslverr;
  logic        proto_a, proto_b;
  logic [7:0]  errcnt_a, errcnt_b;

  int ntot = 0;
  int nbad = 0;

  int          wait_of [2] = '{0, 3};
  int          exp_err [2];
  bit          exp_proto [2];
  logic [31:0] mm [int];

  always #5 clk = ~clk;

  assign psel_a  = psel & ~dsel;
  assign psel_b  = psel & dsel;
  assign prdata  = dsel ? prdata_b  : prdata_a;
  assign pready  = dsel ? pready_b  : pready_a;
  assign pslverr = dsel ? pslverr_b : pslverr_a;

  apb_ram_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .PSEL(psel_a), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_a), .PREADY(pready_a),
    .PSLVERR(pslverr_a), .proto_err(proto_a), .err_cnt(errcnt_a));

  apb_ram_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .PSEL(psel_b), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_b), .PREADY(pready_b),
    .PSLVERR(pslverr_b), .proto_err(proto_b), .err_cnt(errcnt_b));

  // Reference model: word memory keyed by (instance, word index); bad
  // addresses answer with an error and read data 0.
  function automatic void model_xfer(input int d, input bit wr, input logic [31:0] addr,
                                     input logic [31:0] wd, output logic [31:0] erd,
                                     output bit eerr, output bit eknown);
    int key;
    bit is_bad;
    is_bad = ((addr >> 18) != 0) || ((addr % 4) != 0);
    key    = d * 65536 + int'((addr >> 2) & 32'hFFFF);
    eerr   = is_bad;
    eknown = 1'b1;
    erd    = 32'd0;
    if (is_bad) begin
      if (exp_err[d] < 255) exp_err[d]++;
    end else if (wr) begin
      mm[key] = wd;
    end else if (mm.exists(key)) begin
      erd = mm[key];
    end else begin
      eknown = 1'b0;
    end
  endfunction

  // Drives one full APB transfer; entered and left #1 after a rising edge.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic se, output int cyc,
                      output bit stable);
    logic [31:0] first_rd;
    bit done;
    cyc = 1; stable = 1'b1; done = 1'b0; first_rd = 32'd0;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) first_rd = prdata;
      else if (prdata !== first_rd) stable = 1'b0;
      if (pready === 1'b1) begin
        done = 1'b1;
      end else if (cyc > 300) begin
        ntot++; nbad++;
        $display("FAIL xfer_timeout addr=%h got no PREADY within 300 cycles", addr);
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    rd = prdata;
    se = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    ntot++;
    if ({pready_a, pslverr_a, proto_a, errcnt_a, prdata_a} !== 43'd0) begin
      nbad++;
      $display("FAIL reset_w0 got rdy=%b err=%b proto=%b cnt=%0d rd=%h want all 0",
               pready_a, pslverr_a, proto_a, errcnt_a, prdata_a);
    end
    ntot++;
    if ({pready_b, pslverr_b, proto_b, errcnt_b, prdata_b} !== 43'd0) begin
      nbad++;
      $display("FAIL reset_w3 got rdy=%b err=%b proto=%b cnt=%0d rd=%h want all 0",
               pready_b, pslverr_b, proto_b, errcnt_b, prdata_b);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd, erd; logic se; int cyc; bit st, eerr, ek;
    dsel = 1'b0;
    model_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, erd, eerr, ek);
    xfer(1'b1, 32'h10, 32'hDEADBEEF, rd, se, cyc, st);
    ntot++; if (cyc !== 2) begin nbad++; $display("FAIL wr_latency got %0d want 2", cyc); end
    ntot++; if (se !== 1'b0) begin nbad++; $display("FAIL wr_slverr got %b want 0", se); end
    model_xfer(0, 1'b0, 32'h10, 32'h0, erd, eerr, ek);
    xfer(1'b0, 32'h10, 32'h0, rd, se, cyc, st);
    ntot++; if (cyc !== 2) begin nbad++; $display("FAIL rd_latency got %0d want 2", cyc); end
    ntot++; if (rd !== erd) begin nbad++; $display("FAIL rd_data got %h want %h", rd, erd); end
    ntot++; if (errcnt_a !== 8'd0) begin nbad++; $display("FAIL rd_errcnt got %0d want 0", errcnt_a); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd, erd; logic se; int cyc; bit st, eerr, ek;
    dsel = 1'b1;
    model_xfer(1, 1'b1, 32'h10, 32'hCAFEF00D, erd, eerr, ek);
    xfer(1'b1, 32'h10, 32'hCAFEF00D, rd, se, cyc, st);
    ntot++; if (cyc !== 5) begin nbad++; $display("FAIL wait_wr_latency got %0d want 5", cyc); end
    model_xfer(1, 1'b0, 32'h10, 32'h0, erd, eerr, ek);
    xfer(1'b0, 32'h10, 32'h0, rd, se, cyc, st);
    ntot++; if (cyc !== 5) begin nbad++; $display("FAIL wait_rd_latency got %0d want 5", cyc); end
    ntot++; if (rd !== erd) begin nbad++; $display("FAIL wait_rd_data got %h want %h", rd, erd); end
    ntot++; if (st !== 1'b1) begin nbad++; $display("FAIL wait_rd_stable got %b want 1", st); end
    dsel = 1'b0;
  endtask

  task automatic test_addr_errors();
    logic [31:0] rd, erd; logic se; int cyc; bit st, eerr, ek;
    logic [31:0] addrs [6] = '{32'h0, 32'h0004_0000, 32'h13, 32'h0, 32'h10, 32'h13};
    bit          wrs   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] wds   [6] = '{32'hA5A5A5A5, 32'h11111111, 32'h22222222, 32'h0, 32'h0, 32'h0};
    dsel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      model_xfer(0, wrs[i], addrs[i], wds[i], erd, eerr, ek);
      xfer(wrs[i], addrs[i], wds[i], rd, se, cyc, st);
      ntot++;
      if (se !== eerr) begin
        nbad++; $display("FAIL addr_err_slverr i=%0d got %b want %b", i, se, eerr);
      end
      if (ek) begin
        ntot++;
        if (rd !== erd) begin nbad++; $display("FAIL addr_err_data i=%0d got %h want %h", i, rd, erd); end
      end
    end
    ntot++;
    if (errcnt_a !== 8'(exp_err[0])) begin
      nbad++; $display("FAIL addr_err_cnt got %0d want %0d", errcnt_a, exp_err[0]);
    end
  endtask

  task automatic test_no_setup();
    dsel = 1'b0;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h10;
    @(negedge clk);
    ntot++; if (pready !== 1'b0) begin nbad++; $display("FAIL nosetup_early_ready got %b want 0", pready); end
    @(negedge clk);
    ntot++;
    if ({pready, pslverr} !== 2'b11) begin
      nbad++; $display("FAIL nosetup_resp got rdy=%b err=%b want 1 1", pready, pslverr);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    if (exp_err[0] < 255) exp_err[0]++;
    exp_proto[0] = 1'b1;
    ntot++; if (proto_a !== exp_proto[0]) begin nbad++; $display("FAIL nosetup_proto got %b want 1", proto_a); end
    ntot++;
    if (errcnt_a !== 8'(exp_err[0])) begin
      nbad++; $display("FAIL nosetup_cnt got %0d want %0d", errcnt_a, exp_err[0]);
    end
    @(negedge clk);
    ntot++; if (pready !== 1'b0) begin nbad++; $display("FAIL nosetup_single got rdy=%b want 0", pready); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, erd, wd, a; logic se; int cyc; bit st, eerr, ek;
    for (int i = 0; i < 8; i++) begin
      dsel = i[0];
      a  = 32'($urandom_range(0, 63)) << 2;
      wd = $urandom;
      model_xfer(i % 2, 1'b1, a, wd, erd, eerr, ek);
      xfer(1'b1, a, wd, rd, se, cyc, st);
      model_xfer(i % 2, 1'b0, a, 32'h0, erd, eerr, ek);
      xfer(1'b0, a, 32'h0, rd, se, cyc, st);
      ntot++;
      if (rd !== erd) begin nbad++; $display("FAIL b2b_data i=%0d got %h want %h", i, rd, erd); end
      ntot++;
      if (cyc !== 2 + wait_of[i % 2]) begin
        nbad++; $display("FAIL b2b_latency i=%0d got %0d want %0d", i, cyc, 2 + wait_of[i % 2]);
      end
    end
    dsel = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, wd, a; logic se; int cyc, d; bit st, eerr, ek, wr;
    int kind;
    for (int i = 0; i < 60; i++) begin
      d    = int'($urandom_range(0, 1));
      dsel = d[0];
      wr   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      kind = int'($urandom_range(0, 9));
      if (kind < 7)       a = 32'($urandom_range(0, 15)) << 2;
      else if (kind == 7) a = (32'h1 << $urandom_range(18, 31)) | (32'($urandom_range(0, 15)) << 2);
      else if (kind == 8) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else                a = 32'h0003_FFFC;
      model_xfer(d, wr, a, wd, erd, eerr, ek);
      xfer(wr, a, wd, rd, se, cyc, st);
      ntot++;
      if (cyc !== 2 + wait_of[d]) begin
        nbad++; $display("FAIL rand_latency i=%0d got %0d want %0d", i, cyc, 2 + wait_of[d]);
      end
      ntot++;
      if (se !== eerr) begin nbad++; $display("FAIL rand_slverr i=%0d a=%h got %b want %b", i, a, se, eerr); end
      if (ek) begin
        ntot++;
        if (rd !== erd) begin nbad++; $display("FAIL rand_data i=%0d a=%h got %h want %h", i, a, rd, erd); end
      end
    end
    ntot++;
    if (errcnt_a !== 8'(exp_err[0])) begin nbad++; $display("FAIL rand_cnt_w0 got %0d want %0d", errcnt_a, exp_err[0]); end
    ntot++;
    if (errcnt_b !== 8'(exp_err[1])) begin nbad++; $display("FAIL rand_cnt_w3 got %0d want %0d", errcnt_b, exp_err[1]); end
    ntot++;
    if (proto_b !== exp_proto[1]) begin nbad++; $display("FAIL rand_proto_w3 got %b want %b", proto_b, exp_proto[1]); end
    dsel = 1'b0;
  endtask

  task automatic test_drop_psel();
    logic [31:0] rd, erd; logic se; int cyc; bit st, eerr, ek;
    dsel = 1'b1;
    model_xfer(1, 1'b1, 32'h20, 32'h11223344, erd, eerr, ek);
    xfer(1'b1, 32'h20, 32'h11223344, rd, se, cyc, st);
    ntot++; if (proto_b !== 1'b0) begin nbad++; $display("FAIL drop_proto_before got %b want 0", proto_b); end
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h12345678;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    ntot++; if (pready !== 1'b0) begin nbad++; $display("FAIL drop_ready got %b want 0", pready); end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    exp_proto[1] = 1'b1;
    ntot++; if (proto_b !== exp_proto[1]) begin nbad++; $display("FAIL drop_proto got %b want 1", proto_b); end
    @(posedge clk); #1;
    model_xfer(1, 1'b0, 32'h20, 32'h0, erd, eerr, ek);
    xfer(1'b0, 32'h20, 32'h0, rd, se, cyc, st);
    ntot++; if (rd !== erd) begin nbad++; $display("FAIL drop_data got %h want %h", rd, erd); end
    dsel = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic se; int cyc; bit st, eerr, ek;
    int guard;
    dsel = 1'b1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h99999999;
    @(posedge clk); #1;
    penable = 1'b1;
    guard = 0;
    @(negedge clk);
    while (pready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    ntot++; if (pready !== 1'b1) begin nbad++; $display("FAIL rstmid_ready_before got %b want 1", pready); end
    rst = 1'b1;
    #1;
    ntot++;
    if ({pready_b, pslverr_b, prdata_b} !== 34'd0) begin
      nbad++; $display("FAIL rstmid_outputs got rdy=%b err=%b rd=%h want 0", pready_b, pslverr_b, prdata_b);
    end
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_err[0] = 0; exp_err[1] = 0; exp_proto[0] = 1'b0; exp_proto[1] = 1'b0;
    @(posedge clk); #1;
    ntot++; if ({proto_a, proto_b} !== 2'b00) begin nbad++; $display("FAIL rstmid_proto got %b%b want 00", proto_a, proto_b); end
    model_xfer(1, 1'b0, 32'h20, 32'h0, erd, eerr, ek);
    xfer(1'b0, 32'h20, 32'h0, rd, se, cyc, st);
    ntot++; if (rd !== erd) begin nbad++; $display("FAIL rstmid_word got %h want %h", rd, erd); end
    dsel = 1'b0;
  endtask

  task automatic test_addr_change();
    logic [31:0] erd; bit eerr, ek; int guard;
    dsel = 1'b1;
    model_xfer(1, 1'b0, 32'h20, 32'h0, erd, eerr, ek);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h20;
    @(posedge clk); #1;
    penable = 1'b1; paddr = 32'h24;
    guard = 0;
    @(negedge clk);
    while (pready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    ntot++; if (pready !== 1'b1) begin nbad++; $display("FAIL chg_ready got %b want 1", pready); end
    ntot++; if (prdata !== erd) begin nbad++; $display("FAIL chg_data got %h want %h", prdata, erd); end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    exp_proto[1] = 1'b1;
    ntot++; if (proto_b !== exp_proto[1]) begin nbad++; $display("FAIL chg_proto got %b want 1", proto_b); end
    dsel = 1'b0;
  endtask

  task automatic test_saturation();
    logic [31:0] rd, erd; logic se; int cyc; bit st, eerr, ek;
    dsel = 1'b0;
    for (int i = 0; i < 300; i++) begin
      model_xfer(0, 1'b1, 32'h2, 32'h0, erd, eerr, ek);
      xfer(1'b1, 32'h2, 32'h0, rd, se, cyc, st);
      ntot++;
      if (se !== eerr || errcnt_a !== 8'(exp_err[0])) begin
        nbad++; $display("FAIL sat_step i=%0d got err=%b cnt=%0d want err=%b cnt=%0d",
                         i, se, errcnt_a, eerr, exp_err[0]);
      end
    end
    ntot++; if (errcnt_a !== 8'd255) begin nbad++; $display("FAIL sat_final got %0d want 255", errcnt_a); end
  endtask

  initial begin
    exp_err[0] = 0; exp_err[1] = 0;
    exp_proto[0] = 1'b0; exp_proto[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    test_write_read();
    test_wait_states();
    test_addr_errors();
    test_no_setup();
    test_back_to_back();
    test_drop_psel();
    test_random();
    test_reset_mid();
    test_addr_change();
    test_saturation();
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
